// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer
//   SPI (mode 0) slave frame controller running entirely in the sclk domain.
//   The first byte of a frame is a command {rw, burst, addr[5:0]}. It is
//   followed by write data bytes or dummy bytes clocked out as read data.
//   Burst frames auto-increment the address, wrapping NUM_REGS-1 -> 0.
//
// Ports
//   sclk       in   SPI clock; posedge state, negedge MISO launch
//   rst_n      in   asynchronous active-low reset
//   cs_n       in   active-low chip select; high asynchronously closes the frame
//   mosi       in   serial data in, MSB first
//   miso       out  serial data out, MSB first; 0 when not sending read data
//   reg_addr   out  register address qualifying reg_rd / reg_wr
//   reg_wdata  out  write data, valid with reg_wr
//   reg_wr     out  combinational write strobe (register file writes on posedge)
//   reg_rd     out  combinational read strobe (reg_rdata latched on posedge)
//   reg_rdata  in   combinational read data for reg_addr
//   busy       out  frame in progress
//   addr_err   out  sticky out-of-range access flag, cleared only by rst_n
module spi_reg_sequencer #(
    parameter int NUM_REGS = 64
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic [5:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addr_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    state_t     st_q, st_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [5:0] addr_q, addr_d;
    logic       burst_q, burst_d;
    logic [7:0] rd_shift_q, rd_shift_d;
    logic       miso_q, miso_d;
    logic       addr_err_q, addr_err_d;

    logic       frame_clr;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [5:0] addr_next;

    function automatic logic in_range(input logic [5:0] a);
        return (int'(a) < NUM_REGS);
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] a);
        if (int'(a) == NUM_REGS - 1) begin
            return 6'd0;
        end
        return a + 6'd1;
    endfunction

    // Frame state is cleared by reset or by deselect; no sclk edge is needed
    // after cs_n rises.
    assign frame_clr = ~rst_n | cs_n;

    always_comb begin
        byte_done  = (bit_cnt_q == 3'd7);
        rx_byte    = {shift_q, mosi};
        addr_next  = wrap_inc(addr_q);

        st_d       = st_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        shift_d    = {shift_q[5:0], mosi};
        addr_d     = addr_q;
        burst_d    = burst_q;
        rd_shift_d = rd_shift_q;
        addr_err_d = addr_err_q;
        reg_wr     = 1'b0;
        reg_rd     = 1'b0;
        reg_addr   = addr_q;
        reg_wdata  = 8'd0;

        case (st_q)
            ST_IDLE: begin
                st_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done) begin
                    burst_d = rx_byte[6];
                    addr_d  = rx_byte[5:0];
                    if (rx_byte[7]) begin
                        // Fetch the first read byte at the command edge so it
                        // can be launched on the very next negedge.
                        reg_addr = rx_byte[5:0];
                        if (in_range(rx_byte[5:0])) begin
                            reg_rd     = 1'b1;
                            rd_shift_d = reg_rdata;
                        end else begin
                            rd_shift_d = 8'd0;
                            addr_err_d = 1'b1;
                        end
                        st_d = ST_RDATA;
                    end else begin
                        st_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (byte_done) begin
                    if (in_range(addr_q)) begin
                        reg_wr    = 1'b1;
                        reg_wdata = rx_byte;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                    if (burst_q) begin
                        addr_d = addr_next;
                    end else begin
                        st_d = ST_IGNORE;
                    end
                end
            end
            ST_RDATA: begin
                if (byte_done) begin
                    if (burst_q) begin
                        // Prefetch the next address while the last bit of
                        // the current byte is being sampled by the master.
                        addr_d   = addr_next;
                        reg_addr = addr_next;
                        if (in_range(addr_next)) begin
                            reg_rd     = 1'b1;
                            rd_shift_d = reg_rdata;
                        end else begin
                            rd_shift_d = 8'd0;
                            addr_err_d = 1'b1;
                        end
                    end else begin
                        st_d = ST_IGNORE;
                    end
                end
            end
            ST_IGNORE: begin
                st_d = ST_IGNORE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        // ~bit_cnt_q == 7 - bit_cnt_q: MSB goes out first.
        miso_d = (st_q == ST_RDATA) ? rd_shift_q[~bit_cnt_q] : 1'b0;
    end

    always_ff @(posedge sclk or posedge frame_clr) begin
        if (frame_clr) begin
            st_q       <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            addr_q     <= 6'd0;
            burst_q    <= 1'b0;
            rd_shift_q <= 8'd0;
        end else begin
            st_q       <= st_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            rd_shift_q <= rd_shift_d;
        end
    end

    // MISO launches on the falling edge so it is stable at the master's
    // sampling posedge.
    always_ff @(negedge sclk or posedge frame_clr) begin
        if (frame_clr) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign miso     = miso_q;
    assign busy     = ~cs_n & (st_q != ST_IDLE);
    assign addr_err = addr_err_q;

endmodule
